// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle parametrised shift/rotate unit with start/busy/done handshake
//
// Purpose:
//   Shifts or rotates a WIDTH-bit operand by amt positions. The unit moves
//   at most STEP bit positions per clock, so an operation takes ceil(amt/STEP)
//   RUN cycles. The mode, amount and operand are captured when start is
//   accepted in IDLE. Input changes while busy have no effect.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - operation request, sampled only in IDLE
//   mode   - 00 SLL, 01 SRL, 10 SRA, 11 ROL (sampled with start)
//   in     - operand (sampled with start)
//   amt    - shift amount 0..WIDTH-1 (sampled with start)
//   busy   - high while not IDLE
//   done   - one-cycle pulse; result/carry valid
//   result - shifted value (registered, held until next completion)
//   carry  - last bit shifted/rotated out (registered, held)

module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [AW-1:0] STEP_L  = AW'(STEP);
  localparam logic [AW:0]   WIDTH_L = (AW+1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [AW-1:0]    r_rem;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  logic [AW-1:0]    w_k;
  logic             w_last;
  logic [AW-1:0]    w_hi_idx;
  logic [AW-1:0]    w_lo_idx;
  logic [AW:0]      w_back;
  logic [WIDTH-1:0] w_shifted;
  logic             w_bit_out;

  // Bits moved this cycle: a full STEP, or whatever is left on the final step.
  assign w_last   = (r_rem <= STEP_L);
  assign w_k      = w_last ? r_rem : STEP_L;
  assign w_back   = WIDTH_L - {1'b0, w_k};
  // Last bit to leave the MSB end is bit WIDTH-k; from the LSB end it is bit k-1.
  // Chaining per-step carries yields the carry of the single full-amount shift.
  assign w_hi_idx = AW'(w_back);
  assign w_lo_idx = w_k - AW'(1);

  always_comb begin
    w_shifted = r_data;
    w_bit_out = 1'b0;
    case (r_mode)
      2'b00: begin
        w_shifted = r_data << w_k;
        w_bit_out = r_data[w_hi_idx];
      end
      2'b01: begin
        w_shifted = r_data >> w_k;
        w_bit_out = r_data[w_lo_idx];
      end
      2'b10: begin
        // The MSB never changes under >>>, so each step replicates the original sign.
        w_shifted = $signed(r_data) >>> w_k;
        w_bit_out = r_data[w_lo_idx];
      end
      default: begin
        // w_k is never 0 in RUN, so w_back stays below WIDTH.
        w_shifted = (r_data << w_k) | (r_data >> w_back);
        w_bit_out = r_data[w_hi_idx];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (amt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= 2'b00;
      r_rem    <= '0;
      r_data   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_data <= in;
            r_rem  <= amt;
            if (amt == '0) begin
              r_result <= in;
              r_carry  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_data <= w_shifted;
          r_rem  <= r_rem - w_k;
          if (w_last) begin
            r_result <= w_shifted;
            r_carry  <= w_bit_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign carry  = r_carry;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter (STEP=1 and STEP=4 instances)

module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] din = '0;
  logic [4:0]  amt = '0;

  logic        busy1, done1, carry1;
  logic [31:0] result1;
  logic        busy4, done4, carry4;
  logic [31:0] result4;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .in(din), .amt(amt),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .in(din), .amt(amt),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ds;
    logic [1:0]  m;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] res;
    logic        car;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        car;
    int          lat;
  } exp_t;

  vec_t vt[9];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] d, input int a);
    logic [31:0] r;
    logic        c;
    if (a == 0) return {1'b0, d};
    case (m)
      2'b00:   begin r = d << a; c = d[32-a]; end
      2'b01:   begin r = d >> a; c = d[a-1]; end
      2'b10:   begin r = 32'($signed(d) >>> a); c = d[a-1]; end
      default: begin r = (d << a) | (d >> (32 - a)); c = d[32-a]; end
    endcase
    return {c, r};
  endfunction

  // One operation on the selected instance; expected values go into the
  // scoreboard at drive time and are popped when done is observed.
  task automatic run_op(input int ds, input logic [1:0] m, input logic [31:0] d,
                        input logic [4:0] a, input logic [31:0] er, input logic ec,
                        input string tag);
    exp_t e;
    int   lat;
    int   bcnt;
    bit   got;
    logic d_o, b_o, c_o;
    logic [31:0] r_o;
    e.res = er;
    e.car = ec;
    e.lat = 1 + (int'(a) + ds - 1) / ds;
    sbq.push_back(e);
    @(negedge clk);
    mode = m; din = d; amt = a;
    if (ds == 4) start4 = 1'b1; else start1 = 1'b1;
    lat = 0; bcnt = 0; got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      d_o = (ds == 4) ? done4 : done1;
      b_o = (ds == 4) ? busy4 : busy1;
      if (b_o) bcnt++;
      if (d_o) got = 1;
    end
    e = sbq.pop_front();
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, lat);
    end else begin
      r_o = (ds == 4) ? result4 : result1;
      c_o = (ds == 4) ? carry4 : carry1;
      chk({tag, "_result"}, r_o, e.res);
      chk({tag, "_carry"}, 32'(c_o), 32'(e.car));
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(e.lat));
      @(negedge clk);
      d_o = (ds == 4) ? done4 : done1;
      chk({tag, "_done_one_cycle"}, 32'(d_o), 32'd0);
    end
  endtask

  initial begin
    logic [32:0] mv;
    logic [31:0] orig;
    int ndone, nidle, idle_gaps;
    int t[3];
    bit done_seen;

    vt[0] = '{1, 2'b00, 32'd2,         5'd2,  32'd8,         1'b0};
    vt[1] = '{1, 2'b00, 32'd56,        5'd2,  32'd224,       1'b0};
    vt[2] = '{1, 2'b00, 32'd12,        5'd2,  32'd48,        1'b0};
    vt[3] = '{4, 2'b10, 32'h80000010,  5'd5,  32'hFC000000,  1'b1};
    vt[4] = '{4, 2'b10, 32'h7FFFFFFF,  5'd31, 32'h00000000,  1'b1};
    vt[5] = '{1, 2'b01, 32'hFFFFFFFF,  5'd31, 32'h00000001,  1'b1};
    vt[6] = '{1, 2'b01, 32'h1234ABCD,  5'd0,  32'h1234ABCD,  1'b0};
    vt[7] = '{4, 2'b11, 32'h80000001,  5'd4,  32'h00000018,  1'b0};
    vt[8] = '{4, 2'b11, 32'hF0000000,  5'd4,  32'h0000000F,  1'b1};

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_result", result1, 32'd0);
    chk("rst_carry", 32'(carry1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-RUN aborts with no done pulse.
    @(negedge clk);
    mode = 2'b00; din = 32'h1; amt = 5'd20; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy_before", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_busy_async", 32'(busy1), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done1) done_seen = 1;
    end
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done1) done_seen = 1;
    end
    chk("midrun_no_done", 32'(done_seen), 32'd0);
    chk("midrun_result_cleared", result1, 32'd0);
    run_op(1, 2'b00, 32'h1, 5'd20, 32'h00100000, 1'b0, "after_rst");

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].ds, vt[i].m, vt[i].d, vt[i].a, vt[i].res, vt[i].car, $sformatf("vec%0d", i));
    end

    // Random operations against the full-amount reference model.
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  rm;
      logic [31:0] rd;
      logic [4:0]  ra;
      rm = 2'($urandom_range(0, 3));
      rd = $urandom;
      ra = 5'($urandom_range(0, 31));
      mv = model(rm, rd, int'(ra));
      run_op((i % 2) ? 4 : 1, rm, rd, ra, mv[31:0], mv[32], $sformatf("rnd%0d", i));
    end

    // Start pulsed every cycle while busy with a changing operand.
    orig = 32'h00ABCDEF;
    @(negedge clk);
    mode = 2'b00; din = orig; amt = 5'd10; start1 = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30 && ndone == 0; i++) begin
      @(negedge clk);
      din = $urandom;
      if (done1) ndone++;
    end
    @(negedge clk);
    start1 = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    chk("hs_done_count", 32'(ndone), 32'd1);
    chk("hs_result", result1, orig << 10);
    chk("hs_carry", 32'(carry1), 32'(orig[22]));
    chk("hs_idle_after", 32'(busy1), 32'd0);

    // Start held high: back-to-back operations.
    @(negedge clk);
    mode = 2'b00; din = 32'd5; amt = 5'd10; start1 = 1'b1;
    ndone = 0; nidle = 0; idle_gaps = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      @(negedge clk);
      if (done1) begin
        t[ndone] = cyc;
        if (ndone > 0 && nidle > 0) idle_gaps++;
        ndone++;
        nidle = 0;
      end else if (!busy1) begin
        nidle++;
      end
    end
    start1 = 1'b0;
    chk("b2b_done_count", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      chk("b2b_gap1", 32'(t[1] - t[0]), 32'd12);
      chk("b2b_gap2", 32'(t[2] - t[1]), 32'd12);
      chk("b2b_idle_gaps", 32'(idle_gaps), 32'd2);
    end
    chk("b2b_result", result1, 32'h00001400);
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
